eq_coeff_loader: RTL and testbench

// - Sequences the per-tap coefficient generator after each equalizer setting change.
// - Fetches coefficients for taps 0..NTAPS-1 from the generator via a req/valid handshake.
// - Writes them into the shadow bank of a double-buffered coefficient RAM.
// - Swaps shadow/active banks only on a filter sample boundary, so the filter never runs on a mixed set.

---
 rtl/eq_coeff_loader.sv | 169 ++++++++++++++++
 tb/tb_eq_coeff_loader.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eq_coeff_loader.sv
`default_nettype none
// ============================================================================
// Module   : eq_coeff_loader
// Brief    : Fetches NTAPS equalizer coefficients over a req/valid handshake,
//            writes them into the shadow bank of a double-buffered RAM and
//            swaps banks on a filter sample boundary. Defining EQ_TIMEOUT_EN
//            adds a WAIT timeout that aborts the reload and sets err.
// Revision : 1.0 - initial release
// ============================================================================
module eq_coeff_loader #(
    parameter int NTAPS   = 16,
    parameter int TAPW    = 8,
    parameter int COEFW   = 16,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       eqVal,
    input  logic             eq_update,
    output logic [7:0]       eq_sel,
    output logic             coef_req,
    output logic [TAPW-1:0]  coef_tap,
    input  logic [COEFW-1:0] coef_data,
    input  logic             coef_valid,
    output logic             wr_en,
    output logic [TAPW-1:0]  wr_addr,
    output logic [COEFW-1:0] wr_data,
    input  logic             sample_strobe,
    output logic             bank_sel,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam logic [2:0] c_idle  = 3'd0;
    localparam logic [2:0] c_req   = 3'd1;
    localparam logic [2:0] c_wait  = 3'd2;
    localparam logic [2:0] c_write = 3'd3;
    localparam logic [2:0] c_arm   = 3'd4;
    localparam logic [2:0] c_swap  = 3'd5;

    localparam logic [TAPW-1:0] c_last_tap = TAPW'(NTAPS - 1);

    logic [2:0]       r_state;
    logic [2:0]       w_state_nxt;
    logic [TAPW-1:0]  r_tap;
    logic [COEFW-1:0] r_data;
    logic [7:0]       r_eq_sel;
    logic [7:0]       r_held;
    logic             r_pending;
    logic             r_bank;
    logic             r_err;
    logic             w_start;
    logic [7:0]       w_start_val;
    logic             w_wait_abort;

    // A new reload may only begin from IDLE or straight out of the SWAP cycle;
    // a live request beats an older held one.
    assign w_start     = ((r_state == c_idle) || (r_state == c_swap)) && (eq_update || r_pending);
    assign w_start_val = eq_update ? eqVal : r_held;

`ifdef EQ_TIMEOUT_EN
    localparam int c_cntw = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_cntw-1:0] c_cnt_last = c_cntw'(TIMEOUT - 1);

    logic [c_cntw-1:0] r_wait_cnt;

    always_ff @(posedge clk) begin
        if (reset || (r_state != c_wait)) begin
            r_wait_cnt <= '0;
        end else if (!coef_valid) begin
            r_wait_cnt <= r_wait_cnt + c_cntw'(1);
        end
    end

    assign w_wait_abort = (r_state == c_wait) && !coef_valid && (r_wait_cnt == c_cnt_last);
`else
    logic w_timeout_unused;
    assign w_timeout_unused = (TIMEOUT != 0);
    assign w_wait_abort     = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_idle: begin
                if (w_start) w_state_nxt = c_req;
            end
            c_req: begin
                w_state_nxt = c_wait;
            end
            c_wait: begin
                if (coef_valid) begin
                    w_state_nxt = c_write;
                end else if (w_wait_abort) begin
                    w_state_nxt = c_idle;
                end
            end
            c_write: begin
                w_state_nxt = (r_tap == c_last_tap) ? c_arm : c_req;
            end
            c_arm: begin
                if (sample_strobe) w_state_nxt = c_swap;
            end
            c_swap: begin
                w_state_nxt = w_start ? c_req : c_idle;
            end
            default: begin
                w_state_nxt = c_idle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= c_idle;
            r_tap     <= '0;
            r_data    <= '0;
            r_eq_sel  <= '0;
            r_held    <= '0;
            r_pending <= 1'b0;
            r_bank    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;

            // Updates arriving mid-reload are parked; only the newest survives.
            if (w_start) begin
                r_eq_sel  <= w_start_val;
                r_tap     <= '0;
                r_err     <= 1'b0;
                r_pending <= 1'b0;
            end else if (eq_update) begin
                r_pending <= 1'b1;
                r_held    <= eqVal;
            end

            if ((r_state == c_wait) && coef_valid) begin
                r_data <= coef_data;
            end

            if ((r_state == c_write) && (r_tap != c_last_tap)) begin
                r_tap <= r_tap + TAPW'(1);
            end

            if (w_wait_abort) begin
                r_err <= 1'b1;
            end

            if ((r_state == c_arm) && sample_strobe) begin
                r_bank <= ~r_bank;
            end
        end
    end

    assign eq_sel   = r_eq_sel;
    assign coef_req = (r_state == c_req) || (r_state == c_wait);
    assign coef_tap = r_tap;
    assign wr_en    = (r_state == c_write);
    assign wr_addr  = r_tap;
    assign wr_data  = r_data;
    assign bank_sel = r_bank;
    assign busy     = (r_state == c_req) || (r_state == c_wait) ||
                      (r_state == c_write) || (r_state == c_arm);
    assign done     = (r_state == c_swap);
    assign err      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_eq_coeff_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_eq_coeff_loader
// Brief    : Self-checking bench for eq_coeff_loader: directed reloads plus
//            randomized traffic compared every cycle with a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_eq_coeff_loader;

    localparam int NTAPS   = 4;
    localparam int TAPW    = 8;
    localparam int COEFW   = 16;
    localparam int TIMEOUT = 8;

    logic             clk;
    logic             reset;
    logic [7:0]       eqVal;
    logic             eq_update;
    logic [7:0]       eq_sel;
    logic             coef_req;
    logic [TAPW-1:0]  coef_tap;
    logic [COEFW-1:0] coef_data;
    logic             coef_valid;
    logic             wr_en;
    logic [TAPW-1:0]  wr_addr;
    logic [COEFW-1:0] wr_data;
    logic             sample_strobe;
    logic             bank_sel;
    logic             busy;
    logic             done;
    logic             err;

    eq_coeff_loader #(
        .NTAPS   (NTAPS),
        .TAPW    (TAPW),
        .COEFW   (COEFW),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .eqVal         (eqVal),
        .eq_update     (eq_update),
        .eq_sel        (eq_sel),
        .coef_req      (coef_req),
        .coef_tap      (coef_tap),
        .coef_data     (coef_data),
        .coef_valid    (coef_valid),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .sample_strobe (sample_strobe),
        .bank_sel      (bank_sel),
        .busy          (busy),
        .done          (done),
        .err           (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;
    bit cmp_en = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit         m_fetching, m_armed, m_done, m_pend, m_bank, m_err;
    int         m_phase;     // 0 request cycle, 1 waiting for data, 2 writing
    int         m_tap, m_waitcnt;
    logic [15:0] m_data;
    logic [7:0]  m_sel, m_held;

    task automatic model_step();
        bit         idle_like, start, nd;
        logic [7:0] sv;
        if (reset) begin
            m_fetching = 0; m_armed = 0; m_done = 0; m_pend = 0; m_bank = 0; m_err = 0;
            m_phase = 0; m_tap = 0; m_waitcnt = 0; m_data = '0; m_sel = '0; m_held = '0;
            return;
        end
        idle_like = !m_fetching && !m_armed;
        start     = idle_like && (eq_update || m_pend);
        sv        = eq_update ? eqVal : m_held;
        if (!idle_like && eq_update) begin
            m_pend = 1;
            m_held = eqVal;
        end
        nd = 0;
        if (m_fetching) begin
            if (m_phase == 0) begin
                m_phase = 1;
                m_waitcnt = 0;
            end else if (m_phase == 1) begin
                if (coef_valid) begin
                    m_data  = coef_data;
                    m_phase = 2;
                end else begin
                    m_waitcnt++;
`ifdef EQ_TIMEOUT_EN
                    if (m_waitcnt == TIMEOUT) begin
                        m_fetching = 0;
                        m_err      = 1;
                    end
`endif
                end
            end else begin
                if (m_tap == NTAPS - 1) begin
                    m_fetching = 0;
                    m_armed    = 1;
                end else begin
                    m_tap++;
                    m_phase = 0;
                end
            end
        end else if (m_armed && sample_strobe) begin
            m_armed = 0;
            m_bank  = !m_bank;
            nd      = 1;
        end
        if (start) begin
            m_fetching = 1; m_phase = 0; m_tap = 0; m_sel = sv; m_err = 0; m_pend = 0;
        end
        m_done = nd;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // ---------------- compare + monitor ----------------
    logic [15:0] wr_log [0:255];
    int          wr_cnt   = 0;
    int          done_cnt = 0;
    logic [7:0]  sel_q [$];

    initial begin
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                chk("eq_sel",   32'(eq_sel),   32'(m_sel));
                chk("coef_req", 32'(coef_req), 32'(m_fetching && m_phase < 2));
                if (m_fetching && m_phase < 2) chk("coef_tap", 32'(coef_tap), 32'(m_tap));
                chk("wr_en",    32'(wr_en),    32'(m_fetching && m_phase == 2));
                if (m_fetching && m_phase == 2) begin
                    chk("wr_addr", 32'(wr_addr), 32'(m_tap));
                    chk("wr_data", 32'(wr_data), 32'(m_data));
                end
                chk("bank_sel", 32'(bank_sel), 32'(m_bank));
                chk("busy",     32'(busy),     32'(m_fetching || m_armed));
                chk("done",     32'(done),     32'(m_done));
                chk("err",      32'(err),      32'(m_err));
            end
            if (wr_en === 1'b1) begin
                wr_log[wr_addr] = wr_data;
                wr_cnt++;
                if (wr_addr == 0) sel_q.push_back(eq_sel);
            end
            if (done === 1'b1) done_cnt++;
        end
    end

    // ---------------- coefficient generator ----------------
    bit gen_dir   = 1;
    bit gen_stray = 0;
    bit gen_hold  = 0;

    initial begin
        int gw;
        int lat;
        gw = 0;
        lat = 2;
        coef_valid = 1'b0;
        coef_data  = '0;
        forever begin
            @(posedge clk);
            #1;
            coef_valid = 1'b0;
            if (coef_req === 1'b1) begin
                gw++;
                if (!gen_hold && gw == lat) begin
                    coef_valid = 1'b1;
                    coef_data  = gen_dir ? 16'(16'h0004 + coef_tap) : 16'($urandom);
                    lat        = gen_dir ? 2 : int'($urandom_range(2, 5));
                end
            end else begin
                gw = 0;
                if (gen_stray && $urandom_range(0, 3) == 0) begin
                    coef_valid = 1'b1;
                    coef_data  = 16'($urandom);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_update(input logic [7:0] v);
        eqVal     = v;
        eq_update = 1'b1;
        tick();
        eq_update = 1'b0;
    endtask

    task automatic run_to_swap(input int target);
        for (int i = 0; i < 600 && done_cnt < target; i++) begin
            sample_strobe = (i % 7 == 6);
            tick();
        end
        sample_strobe = 1'b0;
        chk("swap_reached", 32'(done_cnt), 32'(target));
    endtask

    initial begin
        logic [7:0] s0, s1;
        reset = 1'b1; eqVal = '0; eq_update = 1'b0; sample_strobe = 1'b0;
        repeat (3) tick();
        cmp_en = 1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_bank", 32'(bank_sel), 32'd0);
        chk("rst_eqsel", 32'(eq_sel), 32'd0);
        reset = 1'b0;
        tick();

        // basic reload with swap gating
        for (int k = 0; k < 256; k++) wr_log[k] = '0;
        wr_cnt = 0; done_cnt = 0;
        pulse_update(8'hF4);
        for (int i = 0; i < 100 && wr_cnt < 4; i++) tick();
        chk("basic_wr_cnt", 32'(wr_cnt), 32'd4);
        gen_stray = 1;
        repeat (50) tick();
        gen_stray = 0;
        chk("gate_busy", 32'(busy), 32'd1);
        chk("gate_bank", 32'(bank_sel), 32'd0);
        chk("gate_done_cnt", 32'(done_cnt), 32'd0);
        chk("gate_no_stray_wr", 32'(wr_cnt), 32'd4);
        sample_strobe = 1'b1;
        tick();
        sample_strobe = 1'b0;
        chk("swap_bank", 32'(bank_sel), 32'd1);
        chk("swap_done", 32'(done), 32'd1);
        chk("swap_busy", 32'(busy), 32'd0);
        tick();
        chk("swap_done_once", 32'(done), 32'd0);
        for (int k = 0; k < 4; k++) chk("basic_coef", 32'(wr_log[k]), 32'h0004 + 32'(k));
        chk("basic_eqsel", 32'(eq_sel), 32'hF4);
        repeat (3) tick();
        chk("basic_done_cnt", 32'(done_cnt), 32'd1);

        // back-to-back updates: 8'h12 is superseded by 8'h34
        sel_q.delete();
        done_cnt = 0;
        pulse_update(8'hF4);
        repeat (3) tick();
        pulse_update(8'h12);
        tick();
        pulse_update(8'h34);
        run_to_swap(2);
        repeat (3) tick();
        s0 = (sel_q.size() > 0) ? sel_q[0] : 8'h00;
        s1 = (sel_q.size() > 1) ? sel_q[1] : 8'h00;
        chk("b2b_fetches", 32'(sel_q.size()), 32'd2);
        chk("b2b_first", 32'(s0), 32'hF4);
        chk("b2b_second", 32'(s1), 32'h34);
        chk("b2b_bank", 32'(bank_sel), 32'd1);

        // reset in the middle of a fetch
        pulse_update(8'h5A);
        for (int i = 0; i < 100 && !(coef_req === 1'b1 && coef_tap == 2); i++) tick();
        chk("mid_reached_tap2", 32'(coef_tap), 32'd2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_req", 32'(coef_req), 32'd0);
        chk("mid_busy", 32'(busy), 32'd0);
        chk("mid_bank", 32'(bank_sel), 32'd0);
        wr_cnt = 0;
        repeat (10) tick();
        chk("mid_no_wr", 32'(wr_cnt), 32'd0);
        done_cnt = 0;
        pulse_update(8'h77);
        chk("restart_req", 32'(coef_req), 32'd1);
        chk("restart_tap", 32'(coef_tap), 32'd0);
        run_to_swap(1);
        tick();
        chk("restart_bank", 32'(bank_sel), 32'd1);

`ifdef EQ_TIMEOUT_EN
        // withhold data on tap 1 until the loader gives up
        done_cnt = 0;
        pulse_update(8'h3C);
        for (int i = 0; i < 100 && !(coef_req === 1'b1 && coef_tap == 1); i++) tick();
        gen_hold = 1;
        for (int i = 0; i < 40 && err !== 1'b1; i++) tick();
        gen_hold = 0;
        chk("to_err", 32'(err), 32'd1);
        chk("to_busy", 32'(busy), 32'd0);
        chk("to_req", 32'(coef_req), 32'd0);
        chk("to_bank", 32'(bank_sel), 32'd1);
        chk("to_no_done", 32'(done_cnt), 32'd0);
        pulse_update(8'h3D);
        chk("to_err_clr", 32'(err), 32'd0);
        run_to_swap(1);
        tick();
        chk("to_recover_bank", 32'(bank_sel), 32'd0);
`endif

        // randomized traffic including stray valids/strobes and resets
        gen_dir = 0;
        gen_stray = 1;
        for (int i = 0; i < 4000; i++) begin
            eq_update     = ($urandom_range(0, 24) == 0);
            eqVal         = 8'($urandom);
            sample_strobe = ($urandom_range(0, 5) == 0);
            reset         = ($urandom_range(0, 999) == 0);
            tick();
        end
        eq_update = 1'b0; sample_strobe = 1'b0; reset = 1'b0;
        repeat (5) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

endmodule
`default_nettype wire
